ahb_lite_decoder_mux: RTL and testbench



---
 rtl/ahb_lite_decoder_mux_if.sv | 28 ++
 rtl/ahb_lite_decoder_mux.sv | 104 ++++++++++
 tb/tb_ahb_lite_decoder_mux.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/ahb_lite_decoder_mux_if.sv
// AHB-Lite bus bundle between the master, the decoder/mux and the four peripheral slaves.
// The slave modport is the decoder's view; the master modport drives the other side.
interface ahb_lite_decoder_mux_if;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HREADY;
  logic        HRESP;
  logic [31:0] HRDATA;
  logic        HSEL_S0, HSEL_S1, HSEL_S2, HSEL_S3;
  logic        HREADYOUT_S0, HREADYOUT_S1, HREADYOUT_S2, HREADYOUT_S3;
  logic [31:0] HRDATA_S0, HRDATA_S1, HRDATA_S2, HRDATA_S3;

  modport slave (
    input  HADDR, HTRANS,
    input  HREADYOUT_S0, HREADYOUT_S1, HREADYOUT_S2, HREADYOUT_S3,
    input  HRDATA_S0, HRDATA_S1, HRDATA_S2, HRDATA_S3,
    output HREADY, HRESP, HRDATA,
    output HSEL_S0, HSEL_S1, HSEL_S2, HSEL_S3
  );

  modport master (
    output HADDR, HTRANS,
    output HREADYOUT_S0, HREADYOUT_S1, HREADYOUT_S2, HREADYOUT_S3,
    output HRDATA_S0, HRDATA_S1, HRDATA_S2, HRDATA_S3,
    input  HREADY, HRESP, HRDATA,
    input  HSEL_S0, HSEL_S1, HSEL_S2, HSEL_S3
  );
endinterface

// File: rtl/ahb_lite_decoder_mux.sv
// AHB-Lite address decoder, HREADY/HRDATA mux and two-cycle ERROR default slave.
// Optional first-error address capture enabled by AHB_DECODER_ERR_CAPTURE_EN.
module ahb_lite_decoder_mux #(
  parameter logic [7:0] S0_BASE = 8'h00,
  parameter logic [7:0] S1_BASE = 8'h50,
  parameter logic [7:0] S2_BASE = 8'h51,
  parameter logic [7:0] S3_BASE = 8'h52
) (
  input logic                   HCLK,
  input logic                   HRESET,
  ahb_lite_decoder_mux_if.slave bus
`ifdef AHB_DECODER_ERR_CAPTURE_EN
  ,
  output logic [31:0]           ERR_ADDR,
  output logic                  ERR_VALID,
  input  logic                  ERR_CLR
`endif
);

  typedef enum logic [1:0] {StIdle, StErr1, StErr2} def_state_e;

  def_state_e  state_q, state_d;
  logic [4:0]  sel_dec;  // one-hot {DEF, S3, S2, S1, S0}
  logic [4:0]  sel_q;
  logic        hready;
  logic        hresp;
  logic [31:0] hrdata;
  logic        err_start;

  // Equal bases resolve to the lowest index via the if-chain order.
  always_comb begin
    sel_dec = 5'b0;
    if (bus.HADDR[31:24] == S0_BASE)      sel_dec[0] = 1'b1;
    else if (bus.HADDR[31:24] == S1_BASE) sel_dec[1] = 1'b1;
    else if (bus.HADDR[31:24] == S2_BASE) sel_dec[2] = 1'b1;
    else if (bus.HADDR[31:24] == S3_BASE) sel_dec[3] = 1'b1;
    else                                  sel_dec[4] = 1'b1;
  end

  assign bus.HSEL_S0 = sel_dec[0];
  assign bus.HSEL_S1 = sel_dec[1];
  assign bus.HSEL_S2 = sel_dec[2];
  assign bus.HSEL_S3 = sel_dec[3];

  assign err_start = hready & sel_dec[4] & bus.HTRANS[1];

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      sel_q   <= 5'b0;
      state_q <= StIdle;
    end else begin
      if (hready) sel_q <= sel_dec;
      state_q <= state_d;
    end
  end

  // ERR1 always advances; ERR2 can re-enter ERR1 for back-to-back unmapped transfers.
  always_comb begin
    state_d = StIdle;
    if (err_start)              state_d = StErr1;
    else if (state_q == StErr1) state_d = StErr2;
  end

  // Zero sel_q (only after reset) behaves as an idle bus: ready, OKAY, zero data.
  always_comb begin
    hready = 1'b1;
    hresp  = 1'b0;
    hrdata = 32'h0;
    case (sel_q)
      5'b00001: begin hready = bus.HREADYOUT_S0; hrdata = bus.HRDATA_S0; end
      5'b00010: begin hready = bus.HREADYOUT_S1; hrdata = bus.HRDATA_S1; end
      5'b00100: begin hready = bus.HREADYOUT_S2; hrdata = bus.HRDATA_S2; end
      5'b01000: begin hready = bus.HREADYOUT_S3; hrdata = bus.HRDATA_S3; end
      5'b10000: begin
        hready = (state_q != StErr1);
        hresp  = (state_q != StIdle);
      end
      default: ;
    endcase
  end

  assign bus.HREADY = hready;
  assign bus.HRESP  = hresp;
  assign bus.HRDATA = hrdata;

  logic unused_bits;
  assign unused_bits = ^{bus.HADDR[23:0], bus.HTRANS[0]};

`ifdef AHB_DECODER_ERR_CAPTURE_EN
  // A new capture takes priority over a coincident clear.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      ERR_ADDR  <= 32'h0;
      ERR_VALID <= 1'b0;
    end else if (err_start && !ERR_VALID) begin
      ERR_ADDR  <= bus.HADDR;
      ERR_VALID <= 1'b1;
    end else if (ERR_CLR) begin
      ERR_VALID <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_ahb_lite_decoder_mux.sv
// Directed self-checking bench for ahb_lite_decoder_mux; checks error capture when
// AHB_DECODER_ERR_CAPTURE_EN is defined.
module tb_ahb_lite_decoder_mux;
  logic        HCLK = 1'b0;
  logic        HRESET = 1'b1;
  logic [31:0] ERR_ADDR;
  logic        ERR_VALID;
  logic        ERR_CLR = 1'b0;
  int          n_checks = 0;
  int          n_fail = 0;

  ahb_lite_decoder_mux_if bus ();

  ahb_lite_decoder_mux dut (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .bus       (bus.slave)
`ifdef AHB_DECODER_ERR_CAPTURE_EN
    ,
    .ERR_ADDR  (ERR_ADDR),
    .ERR_VALID (ERR_VALID),
    .ERR_CLR   (ERR_CLR)
`endif
  );

`ifndef AHB_DECODER_ERR_CAPTURE_EN
  assign ERR_ADDR  = 32'h0;
  assign ERR_VALID = 1'b0;
`endif

  always #5 HCLK = ~HCLK;

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_rsp(input string tag, input logic rdy, input logic rsp);
    chk({tag, "_hready"}, {31'b0, bus.HREADY}, {31'b0, rdy});
    chk({tag, "_hresp"},  {31'b0, bus.HRESP},  {31'b0, rsp});
  endtask

  function automatic logic [31:0] hsel_vec();
    return {28'b0, bus.HSEL_S3, bus.HSEL_S2, bus.HSEL_S1, bus.HSEL_S0};
  endfunction

  initial begin
    bus.HADDR        = 32'h5000_0000;
    bus.HTRANS       = 2'b10;
    bus.HREADYOUT_S0 = 1'b1;
    bus.HREADYOUT_S1 = 1'b0;
    bus.HREADYOUT_S2 = 1'b1;
    bus.HREADYOUT_S3 = 1'b1;
    bus.HRDATA_S0    = 32'hAAAA_0000;
    bus.HRDATA_S1    = 32'h0;
    bus.HRDATA_S2    = 32'h0;
    bus.HRDATA_S3    = 32'h3333_3333;

    // Reset for two cycles with S1 stalling
    tick();
    tick();
    chk_rsp("reset", 1'b1, 1'b0);
    chk("reset_hrdata", bus.HRDATA, 32'h0);
    chk("reset_hsel_tracks", hsel_vec(), 32'h2);
`ifdef AHB_DECODER_ERR_CAPTURE_EN
    chk("reset_err_valid", {31'b0, ERR_VALID}, 32'h0);
    chk("reset_err_addr", ERR_ADDR, 32'h0);
`endif
    HRESET = 1'b0;
    bus.HTRANS = 2'b00;
    bus.HADDR  = 32'h0;
    bus.HREADYOUT_S1 = 1'b1;
    #1;
    chk("idle_hsel_s0", hsel_vec(), 32'h1);

    // NONSEQ write then read to S1
    bus.HADDR  = 32'h5000_0000;
    bus.HTRANS = 2'b10;
    #1;
    chk("wr_addr_hsel", hsel_vec(), 32'h2);
    tick();
    bus.HRDATA_S1 = 32'h0000_000A;
    chk("rd_addr_hsel", hsel_vec(), 32'h2);
    chk_rsp("wr_data", 1'b1, 1'b0);
    tick();
    bus.HTRANS = 2'b00;
    bus.HADDR  = 32'h0;
    #1;
    chk("rd_data", bus.HRDATA, 32'h0000_000A);
    chk_rsp("rd_data", 1'b1, 1'b0);
    tick();

    // S2 read with three wait states, S3 address held meanwhile
    bus.HADDR  = 32'h5100_0004;
    bus.HTRANS = 2'b10;
    bus.HREADYOUT_S2 = 1'b0;
    bus.HRDATA_S2 = 32'h1234_5678;
    tick();
    bus.HADDR = 32'h5200_0000;
    #1;
    chk("s3_addr_hsel", hsel_vec(), 32'h8);
    chk("s2_wait1", {31'b0, bus.HREADY}, 32'h0);
    tick();
    chk("s2_wait2", {31'b0, bus.HREADY}, 32'h0);
    tick();
    chk("s2_wait3", {31'b0, bus.HREADY}, 32'h0);
    bus.HREADYOUT_S2 = 1'b1;
    #1;
    chk_rsp("s2_done", 1'b1, 1'b0);
    chk("s2_data", bus.HRDATA, 32'h1234_5678);
    tick();
    bus.HTRANS = 2'b00;
    #1;
    chk("s3_data", bus.HRDATA, 32'h3333_3333);

    // Unmapped NONSEQ: ERR1, ERR2, then OKAY
    bus.HADDR  = 32'h7000_0000;
    bus.HTRANS = 2'b10;
    #1;
    chk("unmapped_hsel", hsel_vec(), 32'h0);
    tick();
    bus.HADDR  = 32'h0;
    bus.HTRANS = 2'b00;
    #1;
    chk_rsp("err1", 1'b0, 1'b1);
    chk("err1_hrdata", bus.HRDATA, 32'h0);
    tick();
    chk_rsp("err2", 1'b1, 1'b1);
    tick();
    chk_rsp("err_after", 1'b1, 1'b0);
`ifdef AHB_DECODER_ERR_CAPTURE_EN
    chk("cap_valid", {31'b0, ERR_VALID}, 32'h1);
    chk("cap_addr", ERR_ADDR, 32'h7000_0000);
`endif

    // IDLE to unmapped address: OKAY, no wait
    bus.HADDR = 32'h7000_0000;
    tick();
    chk_rsp("idle_unmapped", 1'b1, 1'b0);
    chk("idle_unmapped_hrdata", bus.HRDATA, 32'h0);

    // Back-to-back unmapped NONSEQ
    bus.HTRANS = 2'b10;
    tick();
    bus.HADDR = 32'h8000_0010;
    #1;
    chk_rsp("b2b_err1a", 1'b0, 1'b1);
    tick();
    chk_rsp("b2b_err2a", 1'b1, 1'b1);
    tick();
    bus.HADDR  = 32'h0;
    bus.HTRANS = 2'b00;
    #1;
    chk_rsp("b2b_err1b", 1'b0, 1'b1);
    tick();
    chk_rsp("b2b_err2b", 1'b1, 1'b1);
    tick();
    chk_rsp("b2b_after", 1'b1, 1'b0);
`ifdef AHB_DECODER_ERR_CAPTURE_EN
    chk("b2b_cap_valid", {31'b0, ERR_VALID}, 32'h1);
    chk("b2b_cap_addr", ERR_ADDR, 32'h7000_0000);

    // Clear, then clear coinciding with a new capture
    ERR_CLR = 1'b1;
    tick();
    ERR_CLR = 1'b0;
    chk("clr_valid", {31'b0, ERR_VALID}, 32'h0);
    bus.HADDR  = 32'h9000_0000;
    bus.HTRANS = 2'b10;
    ERR_CLR    = 1'b1;
    tick();
    ERR_CLR    = 1'b0;
    bus.HADDR  = 32'h0;
    bus.HTRANS = 2'b00;
    chk("clr_cap_valid", {31'b0, ERR_VALID}, 32'h1);
    chk("clr_cap_addr", ERR_ADDR, 32'h9000_0000);
    tick();
    tick();
`endif

    // Reset mid-transfer with stalled S1
    bus.HADDR  = 32'h5000_0000;
    bus.HTRANS = 2'b10;
    bus.HREADYOUT_S1 = 1'b0;
    tick();
    chk("stall_before_rst", {31'b0, bus.HREADY}, 32'h0);
    HRESET = 1'b1;
    tick();
    HRESET = 1'b0;
    bus.HTRANS = 2'b00;
    chk_rsp("mid_reset", 1'b1, 1'b0);
    chk("mid_reset_hrdata", bus.HRDATA, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
